// File: rtl/fmul32_round.sv
// FMUL32 normalize/round/pack stage: two-stage valid/ready pipeline producing a packed IEEE-754 single.
// Optional exception flags (out_flags, sticky_flags, flags_clr) are enabled by defining FMUL32_EXC_FLAGS_EN.
module fmul32_round #(
   parameter int EXP_W = 10,
   parameter int BIAS  = 127
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_val,
   output logic                    in_rdy,
   input  logic                    sign,
   input  logic signed [EXP_W-1:0] exp_sum,
   input  logic [47:0]             mant_prod,
   input  logic [1:0]              rmode,
   input  logic                    spec_val,
   input  logic [31:0]             spec_res,
   output logic                    out_val,
   input  logic                    out_rdy,
`ifdef FMUL32_EXC_FLAGS_EN
   input  logic                    flags_clr,
   output logic [2:0]              out_flags,
   output logic [2:0]              sticky_flags,
`endif
   output logic [31:0]             result
);

   // Two guard bits keep exp_sum+1 and the rounding carry from wrapping.
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] E_ZERO = EW'(32'sd0);
   localparam logic signed [EW-1:0] E_ONE  = EW'(32'sd1);
   localparam logic signed [EW-1:0] E_OVF  = EW'(2 * BIAS + 1);

   logic                 s1_val_q;
   logic [23:0]          s1_m_q,    s1_m_d;
   logic                 s1_g_q,    s1_g_d;
   logic                 s1_s_q,    s1_s_d;
   logic signed [EW-1:0] s1_e_q,    s1_e_d;
   logic                 s1_sign_q;
   logic [1:0]           s1_rmode_q;
   logic                 s1_spec_q;
   logic [31:0]          s1_spec_res_q;

   logic                 out_val_q;
   logic [31:0]          result_q,  result_d;
   logic                 inc_d;
   logic [24:0]          mr_d;
   logic [22:0]          frac_d;
   logic signed [EW-1:0] e_rnd_d;
   logic                 uf_hit;
   logic                 of_hit;

   logic                 s2_adv;
   logic                 s1_adv;

   assign s2_adv  = !out_val_q || out_rdy;
   assign s1_adv  = s2_adv || !s1_val_q;
   assign in_rdy  = s1_adv;
   assign out_val = out_val_q;
   assign result  = result_q;

   // Stage-1 normalize: pick the product window based on the leading bit.
   always_comb begin
      s1_m_d = mant_prod[46:23];
      s1_g_d = mant_prod[22];
      s1_s_d = |mant_prod[21:0];
      s1_e_d = {{2{exp_sum[EXP_W-1]}}, exp_sum};
      if (mant_prod[47]) begin
         s1_m_d = mant_prod[47:24];
         s1_g_d = mant_prod[23];
         s1_s_d = |mant_prod[22:0];
         s1_e_d = {{2{exp_sum[EXP_W-1]}}, exp_sum} + E_ONE;
      end else begin
         s1_m_d = mant_prod[46:23];
      end
   end

   // Stage-1 register
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_val_q      <= 1'b0;
         s1_m_q        <= 24'd0;
         s1_g_q        <= 1'b0;
         s1_s_q        <= 1'b0;
         s1_e_q        <= E_ZERO;
         s1_sign_q     <= 1'b0;
         s1_rmode_q    <= 2'b00;
         s1_spec_q     <= 1'b0;
         s1_spec_res_q <= 32'd0;
      end else if (s1_adv) begin
         s1_val_q <= in_val;
         if (in_val) begin
            s1_m_q        <= s1_m_d;
            s1_g_q        <= s1_g_d;
            s1_s_q        <= s1_s_d;
            s1_e_q        <= s1_e_d;
            s1_sign_q     <= sign;
            s1_rmode_q    <= rmode;
            s1_spec_q     <= spec_val;
            s1_spec_res_q <= spec_res;
         end
      end
   end

   assign uf_hit = (s1_e_q <= E_ZERO);
   assign of_hit = (e_rnd_d >= E_OVF);

   // Stage-2 round and pack, including overflow/underflow/special overrides
   always_comb begin
      inc_d = 1'b0;
      case (s1_rmode_q)
         2'b00:   inc_d = s1_g_q & (s1_s_q | s1_m_q[0]);
         2'b01:   inc_d = 1'b0;
         2'b10:   inc_d = (s1_g_q | s1_s_q) & !s1_sign_q;
         2'b11:   inc_d = (s1_g_q | s1_s_q) & s1_sign_q;
         default: inc_d = 1'b0;
      endcase
      mr_d = {1'b0, s1_m_q} + {24'd0, inc_d};
      // A carry out leaves 1.000..., so the shifted window is all zeros.
      if (mr_d[24]) begin
         frac_d  = mr_d[23:1];
         e_rnd_d = s1_e_q + E_ONE;
      end else begin
         frac_d  = mr_d[22:0];
         e_rnd_d = s1_e_q;
      end
      result_d = {s1_sign_q, e_rnd_d[7:0], frac_d};
      if (s1_spec_q) begin
         result_d = s1_spec_res_q;
      end else if (uf_hit) begin
         result_d = {s1_sign_q, 31'd0};
      end else if (of_hit) begin
         case (s1_rmode_q)
            2'b00:   result_d = {s1_sign_q, 31'h7F800000};
            2'b01:   result_d = {s1_sign_q, 31'h7F7FFFFF};
            2'b10:   result_d = s1_sign_q ? 32'hFF7FFFFF : 32'h7F800000;
            2'b11:   result_d = s1_sign_q ? 32'hFF800000 : 32'h7F7FFFFF;
            default: result_d = {s1_sign_q, 31'h7F800000};
         endcase
      end else begin
         result_d = {s1_sign_q, e_rnd_d[7:0], frac_d};
      end
   end

   // Stage-2 output register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_val_q <= 1'b0;
         result_q  <= 32'd0;
      end else if (s2_adv) begin
         out_val_q <= s1_val_q;
         if (s1_val_q) begin
            result_q <= result_d;
         end
      end
   end

`ifdef FMUL32_EXC_FLAGS_EN
   logic [2:0] flags_q, flags_d;
   logic [2:0] sticky_q;

   assign out_flags    = flags_q;
   assign sticky_flags = sticky_q;

   // Exception flags {of, uf, nx} for the beat in stage 1
   always_comb begin
      flags_d = 3'b000;
      if (s1_spec_q) begin
         flags_d = 3'b000;
      end else if (uf_hit) begin
         flags_d = 3'b011;
      end else if (of_hit) begin
         flags_d = 3'b101;
      end else begin
         flags_d = {2'b00, s1_g_q | s1_s_q};
      end
   end

   // Flags travel with the result; sticky accumulates on output transfers, clear wins
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q  <= 3'b000;
         sticky_q <= 3'b000;
      end else begin
         if (s2_adv && s1_val_q) begin
            flags_q <= flags_d;
         end
         if (flags_clr) begin
            sticky_q <= 3'b000;
         end else if (out_val_q && out_rdy) begin
            sticky_q <= sticky_q | flags_q;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fmul32_round.sv
// Directed-vector bench for fmul32_round: rounding table, latency, backpressure and mid-flight reset.
module tb_fmul32_round;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_val;
   logic        in_rdy;
   logic        sign;
   logic [9:0]  exp_sum;
   logic [47:0] mant_prod;
   logic [1:0]  rmode;
   logic        spec_val;
   logic [31:0] spec_res;
   logic        out_val;
   logic        out_rdy;
   logic [31:0] result;
`ifdef FMUL32_EXC_FLAGS_EN
   logic        flags_clr;
   logic [2:0]  out_flags;
   logic [2:0]  sticky_flags;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fmul32_round #(.EXP_W(10), .BIAS(127)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_val       (in_val),
      .in_rdy       (in_rdy),
      .sign         (sign),
      .exp_sum      (exp_sum),
      .mant_prod    (mant_prod),
      .rmode        (rmode),
      .spec_val     (spec_val),
      .spec_res     (spec_res),
      .out_val      (out_val),
      .out_rdy      (out_rdy),
`ifdef FMUL32_EXC_FLAGS_EN
      .flags_clr    (flags_clr),
      .out_flags    (out_flags),
      .sticky_flags (sticky_flags),
`endif
      .result       (result)
   );

   typedef struct {
      logic        sgn;
      logic [9:0]  es;
      logic [47:0] mp;
      logic [1:0]  rm;
      logic        sv;
      logic [31:0] sr;
      logic [31:0] exp_res;
      logic [2:0]  exp_fl;
   } vec_t;

   localparam logic [47:0] MP_SQ    = 48'h900000000000;
   localparam logic [47:0] MP_TIE   = {1'b0, 24'h800001, 1'b1, 22'd0};
   localparam logic [47:0] MP_CARRY = {1'b0, 24'hFFFFFF, 1'b1, 22'd0};
   localparam logic [47:0] MP_TOP   = 48'h800000000000;
   localparam logic [47:0] MP_LOW   = 48'h400000000000;
   localparam logic [47:0] MP_STK   = {1'b0, 24'hC00000, 1'b0, 22'd1};
   localparam int          NV       = 24;

   vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_and_check(input int idx);
      int cyc;
      @(posedge clk); #1;
      sign      = vecs[idx].sgn;
      exp_sum   = vecs[idx].es;
      mant_prod = vecs[idx].mp;
      rmode     = vecs[idx].rm;
      spec_val  = vecs[idx].sv;
      spec_res  = vecs[idx].sr;
      in_val    = 1'b1;
      @(posedge clk); #1;
      in_val = 1'b0;
      cyc    = 1;
      while (!out_val && cyc < 8) begin
         @(posedge clk); #1;
         cyc++;
      end
      check($sformatf("vec%0d_latency", idx), 32'(cyc), 32'd2);
      check($sformatf("vec%0d_result", idx), result, vecs[idx].exp_res);
`ifdef FMUL32_EXC_FLAGS_EN
      check($sformatf("vec%0d_flags", idx), {29'd0, out_flags}, {29'd0, vecs[idx].exp_fl});
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] got[$];
      logic        acc;
      logic        prev_stall;
      logic [31:0] prev_res;
      int          acc_cnt;
      int          drop_at;
      int          seen;

      //            sgn   es        mp        rm     sv    sr            exp_res       exp_fl
      vecs[0]  = '{1'b0, 10'd127,  MP_SQ,    2'b00, 1'b0, 32'd0,        32'h40100000, 3'b000};
      vecs[1]  = '{1'b1, 10'd127,  MP_SQ,    2'b00, 1'b0, 32'd0,        32'hC0100000, 3'b000};
      vecs[2]  = '{1'b0, 10'd127,  MP_TIE,   2'b00, 1'b0, 32'd0,        32'h3F800002, 3'b001};
      vecs[3]  = '{1'b0, 10'd127,  MP_TIE,   2'b01, 1'b0, 32'd0,        32'h3F800001, 3'b001};
      vecs[4]  = '{1'b1, 10'd127,  MP_TIE,   2'b11, 1'b0, 32'd0,        32'hBF800002, 3'b001};
      vecs[5]  = '{1'b0, 10'd127,  MP_TIE,   2'b10, 1'b0, 32'd0,        32'h3F800002, 3'b001};
      vecs[6]  = '{1'b1, 10'd127,  MP_TIE,   2'b10, 1'b0, 32'd0,        32'hBF800001, 3'b001};
      vecs[7]  = '{1'b0, 10'd127,  MP_CARRY, 2'b00, 1'b0, 32'd0,        32'h40000000, 3'b001};
      vecs[8]  = '{1'b0, 10'd254,  MP_TOP,   2'b00, 1'b0, 32'd0,        32'h7F800000, 3'b101};
      vecs[9]  = '{1'b0, 10'd254,  MP_TOP,   2'b01, 1'b0, 32'd0,        32'h7F7FFFFF, 3'b101};
      vecs[10] = '{1'b1, 10'd254,  MP_TOP,   2'b01, 1'b0, 32'd0,        32'hFF7FFFFF, 3'b101};
      vecs[11] = '{1'b1, 10'd254,  MP_TOP,   2'b10, 1'b0, 32'd0,        32'hFF7FFFFF, 3'b101};
      vecs[12] = '{1'b0, 10'd254,  MP_TOP,   2'b10, 1'b0, 32'd0,        32'h7F800000, 3'b101};
      vecs[13] = '{1'b0, 10'd254,  MP_TOP,   2'b11, 1'b0, 32'd0,        32'h7F7FFFFF, 3'b101};
      vecs[14] = '{1'b1, 10'd254,  MP_TOP,   2'b11, 1'b0, 32'd0,        32'hFF800000, 3'b101};
      vecs[15] = '{1'b1, 10'd254,  MP_TOP,   2'b00, 1'b0, 32'd0,        32'hFF800000, 3'b101};
      vecs[16] = '{1'b0, 10'd253,  MP_TOP,   2'b00, 1'b0, 32'd0,        32'h7F000000, 3'b000};
      vecs[17] = '{1'b0, 10'd254,  MP_CARRY, 2'b00, 1'b0, 32'd0,        32'h7F800000, 3'b101};
      vecs[18] = '{1'b0, 10'h3FF,  MP_LOW,   2'b00, 1'b0, 32'd0,        32'h00000000, 3'b011};
      vecs[19] = '{1'b1, 10'd0,    MP_LOW,   2'b00, 1'b0, 32'd0,        32'h80000000, 3'b011};
      vecs[20] = '{1'b0, 10'd0,    MP_TOP,   2'b00, 1'b0, 32'd0,        32'h00800000, 3'b000};
      vecs[21] = '{1'b0, 10'd254,  MP_TOP,   2'b00, 1'b1, 32'h7FC00000, 32'h7FC00000, 3'b000};
      vecs[22] = '{1'b0, 10'd127,  MP_STK,   2'b00, 1'b0, 32'd0,        32'h3FC00000, 3'b001};
      vecs[23] = '{1'b0, 10'd127,  MP_STK,   2'b10, 1'b0, 32'd0,        32'h3FC00001, 3'b001};

      rst = 1'b1; in_val = 1'b0; sign = 1'b0; exp_sum = 10'd0; mant_prod = 48'd0;
      rmode = 2'b00; spec_val = 1'b0; spec_res = 32'd0; out_rdy = 1'b1;
`ifdef FMUL32_EXC_FLAGS_EN
      flags_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_out_val", {31'd0, out_val}, 32'd0);
      check("reset_in_rdy", {31'd0, in_rdy}, 32'd1);
      check("reset_result", result, 32'd0);

      for (int i = 0; i < NV; i++) begin
         send_and_check(i);
      end

      // Backpressure: four special beats, output stalled for three cycles
      @(posedge clk); #1;
      out_rdy = 1'b0; spec_val = 1'b1; spec_res = 32'd1; in_val = 1'b1;
      acc_cnt = 0; drop_at = -1; prev_stall = 1'b0; prev_res = 32'd0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         acc = in_val && in_rdy;
         if (out_val && out_rdy) got.push_back(result);
         if (prev_stall) check("bp_hold", result, prev_res);
         prev_stall = out_val && !out_rdy;
         prev_res   = result;
         if (!in_rdy && drop_at < 0) drop_at = acc_cnt;
         @(posedge clk); #1;
         if (acc) acc_cnt++;
         if (acc_cnt < 4) begin
            in_val   = 1'b1;
            spec_res = 32'(acc_cnt + 1);
         end else begin
            in_val = 1'b0;
         end
         out_rdy = (c >= 4);
      end
      check("bp_drop_after", 32'(drop_at), 32'd2);
      check("bp_count", 32'(got.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("bp_order%0d", i), (i < got.size()) ? got[i] : 32'hDEADBEEF, 32'(i + 1));
      end

      // Reset with both stages occupied
      out_rdy = 1'b0; spec_val = 1'b1; spec_res = 32'hA; in_val = 1'b1;
      @(posedge clk); #1;
      spec_res = 32'hB;
      @(posedge clk); #1;
      in_val = 1'b0;
      check("mid_full_out_val", {31'd0, out_val}, 32'd1);
      check("mid_full_in_rdy", {31'd0, in_rdy}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_out_val", {31'd0, out_val}, 32'd0);
      check("mid_rst_in_rdy", {31'd0, in_rdy}, 32'd1);
      check("mid_rst_result", result, 32'd0);
      out_rdy = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_val) seen++;
      end
      check("mid_rst_no_stale", 32'(seen), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
